// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//
// Purpose: bus between the fetch stage and the synchronous instruction
// memory. The fetch stage presents an address combinationally every cycle;
// the memory returns the word for that address one cycle later.
//
// Signals:
//   imem_addr   [AW-1:0]  address driven by the fetch stage
//   imem_rdata  [IW-1:0]  registered read data returned by the memory
//
// Modports:
//   master  fetch-stage side (drives imem_addr, samples imem_rdata)
//   slave   memory side     (samples imem_addr, drives imem_rdata)
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int AW = 8,
    parameter int IW = 16
);
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Purpose: instruction-fetch stage of the pipelined core. Holds the PC and
// the instruction register, drives the synchronous instruction memory, and
// honours the hazard unit's load-use stall, the execute stage's branch
// redirect and the HALT opcode.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-low reset
//   stall_ld    in   active-low stall; 0 holds PC, IR and the in-flight fetch
//   br_taken    in   redirect request from execute
//   br_target   in   redirect address (valid with br_taken)
//   imem        --   instruction-memory bus (master side)
//   ir          out  instruction register (all zeros = NOP / bubble)
//   ir_pc       out  address of the instruction held in ir
//   ir_valid    out  ir holds a real instruction
//   rr1, rr2    out  source-register fields of ir for the hazard unit
//   halted      out  high while fetch is stopped on a HALT instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int              AW       = 8,
    parameter int              IW       = 16,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_ld,
    input  logic              br_taken,
    input  logic [AW-1:0]     br_target,
    fetch_stage_if.master     imem,
    output logic [IW-1:0]     ir,
    output logic [AW-1:0]     ir_pc,
    output logic              ir_valid,
    output logic [3:0]        rr1,
    output logic [3:0]        rr2,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t        state,    state_nxt;
    logic [AW-1:0] pc,       pc_nxt;
    logic [AW-1:0] f_pc,     f_pc_nxt;
    logic          f_v,      f_v_nxt;
    logic [IW-1:0] ir_nxt;
    logic [AW-1:0] ir_pc_nxt;
    logic          ir_valid_nxt;

    logic [3:0]    fetched_op;

    assign fetched_op = imem.imem_rdata[IW-1 -: 4];

    // Memory address. During a stall the in-flight address (f_pc) is
    // re-issued so the same word is presented again next cycle, which
    // avoids any skid buffer. In HALT the frozen pc is presented.
    always_comb begin
        imem.imem_addr = pc;
        if (br_taken) begin
            imem.imem_addr = br_target;
        end else if (state == ST_HALT) begin
            imem.imem_addr = pc;
        end else if (!stall_ld) begin
            imem.imem_addr = f_pc;
        end
    end

    // Next-state logic. Priority: branch, HALT, stall, advance. FILL is an
    // ordinary advance whose in-flight word is known invalid (f_v = 0).
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        f_pc_nxt     = f_pc;
        f_v_nxt      = f_v;
        ir_nxt       = ir;
        ir_pc_nxt    = ir_pc;
        ir_valid_nxt = ir_valid;

        if (br_taken) begin
            pc_nxt       = br_target + AW'(1);
            f_pc_nxt     = br_target;
            f_v_nxt      = 1'b1;
            ir_nxt       = '0;
            ir_valid_nxt = 1'b0;
            state_nxt    = ST_RUN;
        end else if (state == ST_HALT) begin
            // Nothing further is fetched, so whatever is on the bus is stale.
            f_v_nxt = 1'b0;
        end else if (stall_ld) begin
            ir_nxt       = f_v ? imem.imem_rdata : '0;
            ir_valid_nxt = f_v;
            ir_pc_nxt    = f_pc;
            f_pc_nxt     = pc;
            f_v_nxt      = 1'b1;
            pc_nxt       = pc + AW'(1);
            if (state == ST_FILL) begin
                state_nxt = ST_RUN;
            end else if (f_v && (fetched_op == HALT_OP)) begin
                state_nxt = ST_HALT;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FILL;
            pc       <= RESET_PC;
            f_pc     <= RESET_PC;
            f_v      <= 1'b0;
            ir       <= '0;
            ir_pc    <= RESET_PC;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            f_pc     <= f_pc_nxt;
            f_v      <= f_v_nxt;
            ir       <= ir_nxt;
            ir_pc    <= ir_pc_nxt;
            ir_valid <= ir_valid_nxt;
        end
    end

    assign rr1    = ir[7:4];
    assign rr2    = ir[3:0];
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Purpose: self-checking bench for fetch_stage. Each scenario queues its
// stimulus together with the IR contents expected after the edge; the
// entries are popped and compared as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int AW = 8;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_ld;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic [IW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic [3:0]    rr1;
    logic [3:0]    rr2;
    logic          halted;

    fetch_stage_if #(.AW(AW), .IW(IW)) bus ();

    fetch_stage #(.AW(AW), .IW(IW), .RESET_PC(8'h00), .HALT_OP(4'hF)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_ld  (stall_ld),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem      (bus),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .rr1       (rr1),
        .rr2       (rr2),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word for address at edge t is
    // visible after that edge.
    logic [IW-1:0] mem [0:255];
    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    typedef struct {
        logic          stall;
        logic          br;
        logic [AW-1:0] tgt;
        logic [IW-1:0] ir;
        logic [AW-1:0] pc;
        logic          valid;
        logic          chk_pc;
        logic          halt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic plan(input logic s, input logic b, input logic [AW-1:0] t,
                        input logic [IW-1:0] i, input logic [AW-1:0] p,
                        input logic v, input logic c, input logic h);
        exp_t e;
        e.stall = s; e.br = b; e.tgt = t;
        e.ir = i; e.pc = p; e.valid = v; e.chk_pc = c; e.halt = h;
        sb.push_back(e);
    endtask

    task automatic tick(input logic s, input logic b, input logic [AW-1:0] t);
        stall_ld  = s;
        br_taken  = b;
        br_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stall_ld  = 1'b1;
        br_taken  = 1'b0;
        br_target = '0;
        rst       = 1'b1;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (ir !== 16'h0000 || ir_valid !== 1'b0 || ir_pc !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_ir: ir=%h v=%b pc=%h, want ir=0000 v=0 pc=00", ir, ir_valid, ir_pc);
        end
        vectors++;
        if (halted !== 1'b0 || bus.imem_addr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_misc: halted=%b addr=%h, want halted=0 addr=00", halted, bus.imem_addr);
        end
        vectors++;
        if (rr1 !== 4'h0 || rr2 !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_rr: rr1=%h rr2=%h, want 0 0", rr1, rr2);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        exp_t e;
        int   k = 0;
        plan(1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1000, 8'h00, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1001, 8'h01, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1002, 8'h02, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1003, 8'h03, 1'b1, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.stall, e.br, e.tgt);
            vectors++;
            if (ir !== e.ir || ir_valid !== e.valid || halted !== e.halt ||
                (e.chk_pc && ir_pc !== e.pc) || rr1 !== e.ir[7:4] || rr2 !== e.ir[3:0]) begin
                errors++;
                $display("[TB] FAIL sequential step %0d: ir=%h pc=%h v=%b h=%b, want ir=%h pc=%h v=%b h=%b",
                         k, ir, ir_pc, ir_valid, halted, e.ir, e.pc, e.valid, e.halt);
            end
            k++;
        end
    endtask

    task automatic test_single_stall();
        exp_t e;
        int   k = 0;
        stall_ld = 1'b0;
        #1;
        vectors++;
        if (bus.imem_addr !== 8'h04) begin
            errors++;
            $display("[TB] FAIL stall_addr: addr=%h, want 04", bus.imem_addr);
        end
        plan(1'b0, 1'b0, 8'h00, 16'h1003, 8'h03, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1004, 8'h04, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1005, 8'h05, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1006, 8'h06, 1'b1, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.stall, e.br, e.tgt);
            vectors++;
            if (ir !== e.ir || ir_valid !== e.valid || halted !== e.halt ||
                (e.chk_pc && ir_pc !== e.pc) || rr1 !== e.ir[7:4] || rr2 !== e.ir[3:0]) begin
                errors++;
                $display("[TB] FAIL single_stall step %0d: ir=%h pc=%h v=%b h=%b, want ir=%h pc=%h v=%b h=%b",
                         k, ir, ir_pc, ir_valid, halted, e.ir, e.pc, e.valid, e.halt);
            end
            k++;
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   k = 0;
        plan(1'b1, 1'b1, 8'hFE, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h10FE, 8'hFE, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            plan(1'b0, 1'b0, 8'h00, 16'h10FE, 8'hFE, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h10FF, 8'hFF, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1000, 8'h00, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1001, 8'h01, 1'b1, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.stall, e.br, e.tgt);
            vectors++;
            if (ir !== e.ir || ir_valid !== e.valid || halted !== e.halt ||
                (e.chk_pc && ir_pc !== e.pc) || rr1 !== e.ir[7:4] || rr2 !== e.ir[3:0]) begin
                errors++;
                $display("[TB] FAIL wrap step %0d: ir=%h pc=%h v=%b h=%b, want ir=%h pc=%h v=%b h=%b",
                         k, ir, ir_pc, ir_valid, halted, e.ir, e.pc, e.valid, e.halt);
            end
            k++;
        end
    endtask

    task automatic test_branch_during_stall();
        exp_t e;
        int   k = 0;
        stall_ld  = 1'b0;
        br_taken  = 1'b1;
        br_target = 8'h40;
        #1;
        vectors++;
        if (bus.imem_addr !== 8'h40) begin
            errors++;
            $display("[TB] FAIL branch_addr: addr=%h, want 40", bus.imem_addr);
        end
        plan(1'b0, 1'b1, 8'h40, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1040, 8'h40, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1041, 8'h41, 1'b1, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.stall, e.br, e.tgt);
            vectors++;
            if (ir !== e.ir || ir_valid !== e.valid || halted !== e.halt ||
                (e.chk_pc && ir_pc !== e.pc) || rr1 !== e.ir[7:4] || rr2 !== e.ir[3:0]) begin
                errors++;
                $display("[TB] FAIL branch_stall step %0d: ir=%h pc=%h v=%b h=%b, want ir=%h pc=%h v=%b h=%b",
                         k, ir, ir_pc, ir_valid, halted, e.ir, e.pc, e.valid, e.halt);
            end
            k++;
        end
    endtask

    task automatic test_halt();
        exp_t e;
        int   k = 0;
        mem[5] = 16'hF000;
        plan(1'b1, 1'b1, 8'h03, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1003, 8'h03, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1004, 8'h04, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'hF000, 8'h05, 1'b1, 1'b1, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.stall, e.br, e.tgt);
            vectors++;
            if (ir !== e.ir || ir_valid !== e.valid || halted !== e.halt ||
                (e.chk_pc && ir_pc !== e.pc) || rr1 !== e.ir[7:4] || rr2 !== e.ir[3:0]) begin
                errors++;
                $display("[TB] FAIL halt_entry step %0d: ir=%h pc=%h v=%b h=%b, want ir=%h pc=%h v=%b h=%b",
                         k, ir, ir_pc, ir_valid, halted, e.ir, e.pc, e.valid, e.halt);
            end
            k++;
        end
        // pc froze at 7: the advance that loaded the HALT word also moved pc.
        for (int i = 0; i < 10; i++) begin
            tick(1'($urandom_range(0, 1)), 1'b0, 8'h00);
            vectors++;
            if (ir !== 16'hF000 || ir_pc !== 8'h05 || ir_valid !== 1'b1 ||
                halted !== 1'b1 || bus.imem_addr !== 8'h07) begin
                errors++;
                $display("[TB] FAIL halt_hold cycle %0d: ir=%h pc=%h v=%b h=%b addr=%h, want ir=f000 pc=05 v=1 h=1 addr=07",
                         i, ir, ir_pc, ir_valid, halted, bus.imem_addr);
            end
        end
        k = 0;
        plan(1'b1, 1'b1, 8'h10, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1010, 8'h10, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1011, 8'h11, 1'b1, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.stall, e.br, e.tgt);
            vectors++;
            if (ir !== e.ir || ir_valid !== e.valid || halted !== e.halt ||
                (e.chk_pc && ir_pc !== e.pc) || rr1 !== e.ir[7:4] || rr2 !== e.ir[3:0]) begin
                errors++;
                $display("[TB] FAIL halt_resume step %0d: ir=%h pc=%h v=%b h=%b, want ir=%h pc=%h v=%b h=%b",
                         k, ir, ir_pc, ir_valid, halted, e.ir, e.pc, e.valid, e.halt);
            end
            k++;
        end
    endtask

    task automatic test_halt_vs_branch();
        exp_t e;
        int   k = 0;
        // The HALT word at 5 is on the bus when the branch arrives; the
        // branch must discard it.
        plan(1'b1, 1'b1, 8'h04, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1004, 8'h04, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b1, 8'h20, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1020, 8'h20, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1021, 8'h21, 1'b1, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.stall, e.br, e.tgt);
            vectors++;
            if (ir !== e.ir || ir_valid !== e.valid || halted !== e.halt ||
                (e.chk_pc && ir_pc !== e.pc) || rr1 !== e.ir[7:4] || rr2 !== e.ir[3:0]) begin
                errors++;
                $display("[TB] FAIL halt_vs_branch step %0d: ir=%h pc=%h v=%b h=%b, want ir=%h pc=%h v=%b h=%b",
                         k, ir, ir_pc, ir_valid, halted, e.ir, e.pc, e.valid, e.halt);
            end
            k++;
        end
        mem[5] = 16'h1005;
    endtask

    task automatic test_back_to_back_reset();
        exp_t e;
        int   k = 0;
        plan(1'b1, 1'b1, 8'h20, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1020, 8'h20, 1'b1, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.stall, e.br, e.tgt);
            vectors++;
            if (ir !== e.ir || ir_valid !== e.valid || halted !== e.halt ||
                (e.chk_pc && ir_pc !== e.pc) || rr1 !== e.ir[7:4] || rr2 !== e.ir[3:0]) begin
                errors++;
                $display("[TB] FAIL async_pre step %0d: ir=%h pc=%h v=%b h=%b, want ir=%h pc=%h v=%b h=%b",
                         k, ir, ir_pc, ir_valid, halted, e.ir, e.pc, e.valid, e.halt);
            end
            k++;
        end
        // pc is now 0x22 in RUN; drop reset between edges.
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (ir !== 16'h0000 || ir_valid !== 1'b0 || ir_pc !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_ir: ir=%h v=%b pc=%h, want ir=0000 v=0 pc=00", ir, ir_valid, ir_pc);
        end
        vectors++;
        if (halted !== 1'b0 || bus.imem_addr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_pc: halted=%b addr=%h, want halted=0 addr=00", halted, bus.imem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        k = 0;
        plan(1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1000, 8'h00, 1'b1, 1'b1, 1'b0);
        plan(1'b1, 1'b0, 8'h00, 16'h1001, 8'h01, 1'b1, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick(e.stall, e.br, e.tgt);
            vectors++;
            if (ir !== e.ir || ir_valid !== e.valid || halted !== e.halt ||
                (e.chk_pc && ir_pc !== e.pc) || rr1 !== e.ir[7:4] || rr2 !== e.ir[3:0]) begin
                errors++;
                $display("[TB] FAIL async_refill step %0d: ir=%h pc=%h v=%b h=%b, want ir=%h pc=%h v=%b h=%b",
                         k, ir, ir_pc, ir_valid, halted, e.ir, e.pc, e.valid, e.halt);
            end
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1000 + i);
        test_reset();
        test_sequential();
        test_single_stall();
        test_wrap();
        test_branch_during_stall();
        test_halt();
        test_halt_vs_branch();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
